wb_result_select: RTL and testbench
===================================

// Module: wb_result_select
// PURPOSE
//  Registered write-back result selector for the MIPS MEM/WB boundary. Chooses among
//  ALU result, filtered load data, LUI constant and link address, then registers it with
//  rd/reg-write qualifiers. Load byte/half/word extraction, sign/zero extension and
//  misalignment detection happen in this stage, not in the memory stage.
//  Output feeds the register-file write port and the forwarding unit.
// PARAMETERS
//  NBITS     32  datapath width; must be >= 32
//  REGBITS   5   register-index width
// PORTS
//  i_clk           in   1         clock, rising edge
//  i_reset         in   1         asynchronous, active-low reset
//  i_valid         in   1         input beat valid
//  i_stall         in   1         hold output register contents
//  i_flush         in   1         kill the beat being registered
//  i_sel           in   2         00 ALU, 01 LOAD, 10 LUI, 11 LINK
//  i_load_size     in   2         00 byte, 01 half, 10 word, 11 reserved (as word)
//  i_load_unsigned in   1         1 zero-extend, 0 sign-extend the load
//  i_addr_lsb      in   2         effective-address bits [1:0]
//  i_alu_result    in   NBITS     ALU result
//  i_mem_data      in   NBITS     raw aligned word from data memory
//  i_imm16         in   16        instruction immediate
//  i_pc_link       in   NBITS     return address (PC+8)
//  i_rd            in   REGBITS   destination register
//  i_reg_write     in   1         destination write enable
//  o_valid         out  1         registered beat valid
//  o_result        out  NBITS     registered selected result
//  o_rd            out  REGBITS   registered destination
//  o_reg_write     out  1         registered write enable (qualified)
//  o_misaligned    out  1         registered misaligned-load flag
// BEHAVIOUR
//  - Reset (i_reset=0, async): all outputs 0. Released synchronously at the next edge.
//  - Latency 1 cycle; at most one beat held; no internal buffering beyond output register.
//  - Per edge, priority: reset > flush > stall > load.
//    flush: o_valid, o_reg_write, o_misaligned <= 0; o_result, o_rd unchanged.
//    stall (no flush): all outputs hold.
//    otherwise: o_valid <= i_valid; other fields <= computed values.
//    i_valid=0 also forces o_reg_write and o_misaligned to 0.
//  - Little-endian lane extraction:
//    byte: b = i_mem_data[8*lsb +: 8]
//    half: h = i_mem_data[16*lsb[1] +: 16]
//    word: w = i_mem_data[31:0]
//    Extend to NBITS: zero if i_load_unsigned, else sign.
//  - LUI: {imm16,16'h0}, sign-extended from bit 31 to NBITS; i_load_* ignored.
//  - ALU/LINK: pass-through.
//  - Misaligned only for sel=LOAD: half with lsb[0]=1, or word/reserved with lsb!=0.
//    On misaligned: o_misaligned=1, o_reg_write=0, o_result = extracted value (no trap here).
//  - rd = 0 is not special-cased; zero-register suppression belongs to the register file.
//  - Reset asserted mid-stall or mid-flush clears immediately; no beat survives.
// TESTING
//  - Reset: hold i_reset=0 with inputs active -> all outputs 0; release -> first valid
//    beat appears 1 cycle later.
//  - LOAD byte: mem=0x1234_80FF, lsb=1, signed -> 0xFFFF_FF80; unsigned -> 0x0000_0080;
//    lsb=0 signed -> 0xFFFF_FFFF.
//  - LOAD half/word: mem=0x8001_7FFE, half lsb=2 signed -> 0xFFFF_8001;
//    lsb=0 -> 0x0000_7FFE; word lsb=0 -> 0x8001_7FFE.
//    Half lsb=1 -> o_misaligned=1, o_reg_write=0.
//  - LUI/LINK/ALU: imm16=0xABCD -> 0xABCD_0000;
//    sel=11, pc_link=0x0040_0008 -> 0x0040_0008; sel=00 passes i_alu_result.
//  - Stall/flush: load beat A, stall 3 cycles with new inputs -> A held;
//    flush+stall together -> o_valid=0, o_reg_write=0;
//    async reset mid-stall -> outputs 0 without an edge.

Source files
------------

// File: rtl/wb_result_select.sv
// Registered MEM/WB write-back selector: picks ALU, lane-extracted load, LUI or link value
// and registers it with destination/write qualifiers and a misaligned-load flag.
module wb_result_select #(
    parameter int unsigned NBITS   = 32,
    parameter int unsigned REGBITS = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [1:0]         i_sel,
    input  logic [1:0]         i_load_size,
    input  logic               i_load_unsigned,
    input  logic [1:0]         i_addr_lsb,
    input  logic [NBITS-1:0]   i_alu_result,
    input  logic [NBITS-1:0]   i_mem_data,
    input  logic [15:0]        i_imm16,
    input  logic [NBITS-1:0]   i_pc_link,
    input  logic [REGBITS-1:0] i_rd,
    input  logic               i_reg_write,
    output logic               o_valid,
    output logic [NBITS-1:0]   o_result,
    output logic [REGBITS-1:0] o_rd,
    output logic               o_reg_write,
    output logic               o_misaligned
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LUI  = 2'b10;
    localparam logic [1:0] SEL_LINK = 2'b11;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    logic [7:0]       byte_lane_c;
    logic [15:0]      half_lane_c;
    logic [31:0]      word_lane_c;
    logic [NBITS-1:0] load_val_c;
    logic [NBITS-1:0] result_c;
    logic             misaligned_c;

    // Little-endian lane extraction and extension of the load data
    always_comb begin
        byte_lane_c = 8'h00;
        half_lane_c = i_addr_lsb[1] ? i_mem_data[31:16] : i_mem_data[15:0];
        word_lane_c = i_mem_data[31:0];
        load_val_c  = '0;
        case (i_addr_lsb)
            2'd0:    byte_lane_c = i_mem_data[7:0];
            2'd1:    byte_lane_c = i_mem_data[15:8];
            2'd2:    byte_lane_c = i_mem_data[23:16];
            default: byte_lane_c = i_mem_data[31:24];
        endcase
        case (i_load_size)
            SIZE_BYTE: load_val_c = i_load_unsigned ? NBITS'(byte_lane_c)
                                                    : NBITS'($signed(byte_lane_c));
            SIZE_HALF: load_val_c = i_load_unsigned ? NBITS'(half_lane_c)
                                                    : NBITS'($signed(half_lane_c));
            default:   load_val_c = i_load_unsigned ? NBITS'(word_lane_c)
                                                    : NBITS'($signed(word_lane_c));
        endcase
    end

    // Result mux and misalignment detection (reserved size behaves as word)
    always_comb begin
        result_c     = i_alu_result;
        misaligned_c = 1'b0;
        case (i_sel)
            SEL_ALU:  result_c = i_alu_result;
            SEL_LOAD: begin
                result_c = load_val_c;
                if (i_load_size == SIZE_HALF)
                    misaligned_c = i_addr_lsb[0];
                else if (i_load_size[1])
                    misaligned_c = (i_addr_lsb != 2'b00);
            end
            SEL_LUI:  result_c = NBITS'($signed({i_imm16, 16'h0000}));
            SEL_LINK: result_c = i_pc_link;
            default:  result_c = i_alu_result;
        endcase
    end

    // Output register: reset > flush > stall > load
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_valid      <= 1'b0;
            o_result     <= '0;
            o_rd         <= '0;
            o_reg_write  <= 1'b0;
            o_misaligned <= 1'b0;
        end else if (i_flush) begin
            o_valid      <= 1'b0;
            o_reg_write  <= 1'b0;
            o_misaligned <= 1'b0;
        end else if (!i_stall) begin
            o_valid      <= i_valid;
            o_result     <= result_c;
            o_rd         <= i_rd;
            o_reg_write  <= i_valid & i_reg_write & ~misaligned_c;
            o_misaligned <= i_valid & misaligned_c;
        end
    end

endmodule

// File: tb/tb_wb_result_select.sv
// Directed, table-driven bench for wb_result_select with hand-written stall/flush/reset sequences.
module tb_wb_result_select;

    logic        clk;
    logic        rst_n;
    logic        valid, stall, flush;
    logic [1:0]  sel, size, lsb;
    logic        uns;
    logic [31:0] alu, mem, link;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd;
    logic        o_reg_write;
    logic        o_misaligned;

    int checks = 0;
    int errors = 0;

    wb_result_select #(.NBITS(32), .REGBITS(5)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_sel(sel), .i_load_size(size), .i_load_unsigned(uns), .i_addr_lsb(lsb),
        .i_alu_result(alu), .i_mem_data(mem), .i_imm16(imm), .i_pc_link(link),
        .i_rd(rd), .i_reg_write(rw), .o_valid(o_valid), .o_result(o_result), .o_rd(o_rd),
        .o_reg_write(o_reg_write), .o_misaligned(o_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic        valid;
        logic [1:0]  sel, size, lsb;
        logic        uns;
        logic [31:0] alu, mem, link;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] e_res;
        logic        e_rw, e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic v, input logic [1:0] s,
                                input logic [1:0] sz, input logic [1:0] l, input logic u,
                                input logic [31:0] a, input logic [31:0] m,
                                input logic [31:0] lk, input logic [15:0] im,
                                input logic [4:0] r, input logic w,
                                input logic [31:0] er, input logic erw, input logic emis);
        vec_t t;
        t.name = nm; t.valid = v; t.sel = s; t.size = sz; t.lsb = l; t.uns = u;
        t.alu = a; t.mem = m; t.link = lk; t.imm = im; t.rd = r; t.rw = w;
        t.e_res = er; t.e_rw = erw; t.e_mis = emis;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        valid = t.valid; sel = t.sel; size = t.size; lsb = t.lsb; uns = t.uns;
        alu = t.alu; mem = t.mem; link = t.link; imm = t.imm; rd = t.rd; rw = t.rw;
    endtask

    task automatic chk_all(input string nm, input logic v, input logic [31:0] r,
                           input logic [4:0] d, input logic w, input logic m);
        chk({nm, ".valid"},  32'(o_valid),      32'(v));
        chk({nm, ".result"}, o_result,          r);
        chk({nm, ".rd"},     32'(o_rd),         32'(d));
        chk({nm, ".rw"},     32'(o_reg_write),  32'(w));
        chk({nm, ".mis"},    32'(o_misaligned), 32'(m));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t beat_a, beat_b, beat_m;

    initial begin
        // sel size lsb uns
        vecs.push_back(mk("lb_l1_s",  1, 2'b01, 2'b00, 2'd1, 0, 32'h0, 32'h1234_80FF, 32'h0, 16'h0, 5'd1, 1, 32'hFFFF_FF80, 1, 0));
        vecs.push_back(mk("lbu_l1",   1, 2'b01, 2'b00, 2'd1, 1, 32'h0, 32'h1234_80FF, 32'h0, 16'h0, 5'd2, 1, 32'h0000_0080, 1, 0));
        vecs.push_back(mk("lb_l0_s",  1, 2'b01, 2'b00, 2'd0, 0, 32'h0, 32'h1234_80FF, 32'h0, 16'h0, 5'd3, 1, 32'hFFFF_FFFF, 1, 0));
        vecs.push_back(mk("lb_l3_s",  1, 2'b01, 2'b00, 2'd3, 0, 32'h0, 32'h1234_80FF, 32'h0, 16'h0, 5'd4, 1, 32'h0000_0012, 1, 0));
        vecs.push_back(mk("lh_l2_s",  1, 2'b01, 2'b01, 2'd2, 0, 32'h0, 32'h8001_7FFE, 32'h0, 16'h0, 5'd5, 1, 32'hFFFF_8001, 1, 0));
        vecs.push_back(mk("lh_l0_s",  1, 2'b01, 2'b01, 2'd0, 0, 32'h0, 32'h8001_7FFE, 32'h0, 16'h0, 5'd6, 1, 32'h0000_7FFE, 1, 0));
        vecs.push_back(mk("lhu_l2",   1, 2'b01, 2'b01, 2'd2, 1, 32'h0, 32'h8001_7FFE, 32'h0, 16'h0, 5'd7, 1, 32'h0000_8001, 1, 0));
        vecs.push_back(mk("lw_l0",    1, 2'b01, 2'b10, 2'd0, 0, 32'h0, 32'h8001_7FFE, 32'h0, 16'h0, 5'd8, 1, 32'h8001_7FFE, 1, 0));
        vecs.push_back(mk("lh_l1_mis",1, 2'b01, 2'b01, 2'd1, 0, 32'h0, 32'h8001_7FFE, 32'h0, 16'h0, 5'd9, 1, 32'h0000_7FFE, 0, 1));
        vecs.push_back(mk("lw_l2_mis",1, 2'b01, 2'b10, 2'd2, 0, 32'h0, 32'h8001_7FFE, 32'h0, 16'h0, 5'd10, 1, 32'h8001_7FFE, 0, 1));
        vecs.push_back(mk("lrsv_l0",  1, 2'b01, 2'b11, 2'd0, 0, 32'h0, 32'h8001_7FFE, 32'h0, 16'h0, 5'd11, 1, 32'h8001_7FFE, 1, 0));
        vecs.push_back(mk("lrsv_l1",  1, 2'b01, 2'b11, 2'd1, 0, 32'h0, 32'h8001_7FFE, 32'h0, 16'h0, 5'd12, 1, 32'h8001_7FFE, 0, 1));
        vecs.push_back(mk("lui_abcd", 1, 2'b10, 2'b01, 2'd1, 0, 32'h0, 32'h8001_7FFE, 32'h0, 16'hABCD, 5'd13, 1, 32'hABCD_0000, 1, 0));
        vecs.push_back(mk("lui_1234", 1, 2'b10, 2'b10, 2'd3, 1, 32'h0, 32'h0, 32'h0, 16'h1234, 5'd14, 1, 32'h1234_0000, 1, 0));
        vecs.push_back(mk("link",     1, 2'b11, 2'b10, 2'd2, 0, 32'h5, 32'h0, 32'h0040_0008, 16'h0, 5'd31, 1, 32'h0040_0008, 1, 0));
        vecs.push_back(mk("alu",      1, 2'b00, 2'b10, 2'd3, 0, 32'hDEAD_BEEF, 32'h0, 32'h0, 16'hFFFF, 5'd15, 1, 32'hDEAD_BEEF, 1, 0));
        vecs.push_back(mk("alu_norw", 1, 2'b00, 2'b00, 2'd0, 0, 32'h0000_0001, 32'h0, 32'h0, 16'h0, 5'd16, 0, 32'h0000_0001, 0, 0));
        vecs.push_back(mk("invalid",  0, 2'b01, 2'b01, 2'd1, 0, 32'h0, 32'h8001_7FFE, 32'h0, 16'h0, 5'd17, 1, 32'h0000_7FFE, 0, 0));
        vecs.push_back(mk("rd_zero",  1, 2'b00, 2'b00, 2'd0, 0, 32'hCAFE_F00D, 32'h0, 32'h0, 16'h0, 5'd0, 1, 32'hCAFE_F00D, 1, 0));

        beat_a = mk("A", 1, 2'b00, 2'b10, 2'd0, 0, 32'h1111_1111, 32'h0, 32'h0, 16'h0, 5'd3, 1, 32'h1111_1111, 1, 0);
        beat_b = mk("B", 1, 2'b11, 2'b10, 2'd0, 0, 32'h0, 32'h0, 32'h2222_2222, 16'h0, 5'd7, 1, 32'h2222_2222, 1, 0);
        beat_m = mk("M", 1, 2'b01, 2'b10, 2'd1, 0, 32'h0, 32'h89AB_CDEF, 32'h0, 16'h0, 5'd9, 1, 32'h89AB_CDEF, 0, 1);

        // Reset held with an active beat on the inputs
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(beat_a);
        repeat (3) tick();
        chk_all("reset", 0, 32'h0, 5'd0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(beat_b);
        tick();
        chk_all("first_beat", 1, 32'h2222_2222, 5'd7, 1, 0);

        // Table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            tick();
            chk_all(vecs[i].name, vecs[i].valid, vecs[i].e_res, vecs[i].rd, vecs[i].e_rw, vecs[i].e_mis);
        end

        // Stall holds beat A for three cycles while new inputs arrive
        @(negedge clk);
        drive(beat_a);
        tick();
        chk_all("stall_load", 1, 32'h1111_1111, 5'd3, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            drive(beat_b);
            tick();
            chk_all($sformatf("stall_hold%0d", i), 1, 32'h1111_1111, 5'd3, 1, 0);
        end

        // Flush with stall: qualifiers drop, payload holds
        @(negedge clk);
        flush = 1'b1;
        tick();
        chk_all("flush_stall", 0, 32'h1111_1111, 5'd3, 0, 0);

        // Misaligned beat then flush alone
        @(negedge clk);
        flush = 1'b0; stall = 1'b0;
        drive(beat_m);
        tick();
        chk_all("mis_beat", 1, 32'h89AB_CDEF, 5'd9, 0, 1);
        @(negedge clk);
        flush = 1'b1;
        drive(beat_b);
        tick();
        chk_all("flush_only", 0, 32'h89AB_CDEF, 5'd9, 0, 0);

        // Async reset mid-stall clears without a clock edge
        @(negedge clk);
        flush = 1'b0;
        drive(beat_a);
        tick();
        chk_all("pre_rst", 1, 32'h1111_1111, 5'd3, 1, 0);
        @(negedge clk);
        stall = 1'b1;
        drive(beat_b);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 32'h0, 5'd0, 0, 0);
        flush = 1'b1;
        tick();
        chk_all("rst_hold", 0, 32'h0, 5'd0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(beat_b);
        tick();
        chk_all("post_rst", 1, 32'h2222_2222, 5'd7, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
